mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, width of data/register values.
REQ-002 SHALL have parameter PC_SIZE, default 64, width of program counter.
REQ-003 SHALL have parameter REG_ADDR_SIZE, default 5, register index width.
REQ-004 SHALL have port i_clk  input  1  single clock, rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_valid  input  1  MEM stage holds a valid instruction.
REQ-007 SHALL have port i_pc  input  PC_SIZE  instruction PC.
REQ-008 SHALL have port i_rd_addr  input  REG_ADDR_SIZE  destination register.
REQ-009 SHALL have port i_reg_we  input  1  instruction writes rd.
REQ-010 SHALL have port i_mem_to_reg  input  1  rd source is load data (1) or ALU result (0).
REQ-011 SHALL have port i_funct3  input  3  load type.
REQ-012 SHALL have port i_alu_result  input  WORD_SIZE  ALU result / effective address; bits [1:0] give the byte offset.
REQ-013 SHALL have port i_mem_rdata  input  WORD_SIZE  aligned word from data memory.
REQ-014 SHALL have port i_stall  input  1  hold register contents.
REQ-015 SHALL have port i_flush  input  1  kill captured instruction.
REQ-016 SHALL have port o_wb_valid  output  1  registered instruction valid.
REQ-017 SHALL have port o_wb_pc  output  PC_SIZE  registered PC.
REQ-018 SHALL have port o_rd_addr  output  REG_ADDR_SIZE  writeback index.
REQ-019 SHALL have port o_rd_we  output  1  register-file write enable.
REQ-020 SHALL have port o_rd_wdata  output  WORD_SIZE  writeback data (also forwarding source).
REQ-021 SHALL have port o_load_exc  output  1  misaligned or illegal load.
REQ-022 SHALL have port o_instret  output  64  retired-instruction counter.

Function
REQ-023 Latency SHALL be exactly one cycle: inputs sampled at a rising edge appear on the outputs after that edge.
REQ-024 Priority per edge SHALL be: flush > stall > capture.
REQ-025 Flush SHALL set o_wb_valid=0, o_rd_we=0 and o_load_exc=0 while the other fields keep any value; flush overrides a simultaneous stall.
REQ-026 Stall without flush SHALL hold every output, including o_instret, unchanged.
REQ-027 Load extraction SHALL be: funct3 000 LB and 100 LBU select byte [8*off+7:8*off]; 001 LH and 101 LHU select the halfword at off[1]; 010 LW selects the full word. LB and LH sign-extend; LBU and LHU zero-extend.
REQ-028 LH/LHU with off[0]=1, LW with off!=0, or funct3 in {011,110,111} with i_mem_to_reg=1 SHALL set o_load_exc=1, o_rd_we=0 and o_rd_wdata=0.
REQ-029 With i_mem_to_reg=0, o_rd_wdata SHALL equal i_alu_result, and o_load_exc SHALL be 0.
REQ-030 o_rd_we SHALL equal i_valid & i_reg_we & (i_rd_addr!=0) & ~exception.
REQ-031 o_instret SHALL increment by 1 on each capturing edge with i_valid=1 and no exception; it SHALL wrap from 2^64-1 to 0.
REQ-032 Invalid input (i_valid=0) SHALL be captured as a bubble: o_wb_valid=0, o_rd_we=0, no counter increment.

Reset
REQ-033 Asserting i_rst_n=0 SHALL immediately, independent of i_clk, clear all outputs to 0, including o_instret.
REQ-034 The first capture SHALL occur on the first rising edge after i_rst_n deasserts; a reset mid-stall SHALL discard the held instruction.

Structure
REQ-035 WORD_SIZE, PC_SIZE, REG_ADDR_SIZE and the funct3 load encodings SHALL live in the shared RISC-V defines package used by the data_mem stage.
REQ-036 Load extraction SHALL be a combinational sub-module, load_align, instantiated ahead of the pipeline register.

Verification
REQ-037 LB with alu_result=0x1003 and mem_rdata=0x80FF_1234 -> next cycle o_rd_wdata=0xFFFF_FF80, o_rd_we=1.
REQ-038 LHU with off=2 and mem_rdata=0xBEEF_0000 -> o_rd_wdata=0x0000_BEEF; LH with off=1 -> o_load_exc=1, o_rd_we=0, instret unchanged.
REQ-039 ALU op rd=0, reg_we=1 -> o_wb_valid=1, o_rd_we=0, instret +1.
REQ-040 Capture an instruction, then stall for 3 cycles while changing the inputs -> all outputs constant; on release, the new inputs appear one cycle later.
REQ-041 Flush and stall asserted together -> o_wb_valid=0 next cycle; instret unchanged.
REQ-042 Preload instret=0xFFFF_FFFF_FFFF_FFFF via capture sequence or force, capture a valid op -> instret=0; assert i_rst_n=0 between edges -> outputs clear before the next edge.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared RISC-V widths and load funct3 encodings
package mem_wb_stage_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int PC_SIZE       = 64;
  localparam int REG_ADDR_SIZE = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - combinational byte/half/word load extraction
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int WORD_SIZE = mem_wb_stage_pkg::WORD_SIZE
) (
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  input  logic [WORD_SIZE-1:0] rdata,
  output logic [WORD_SIZE-1:0] data,
  output logic                 exc
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  // Any misaligned or unknown encoding yields zero data plus exc.
  always_comb begin
    data = '0;
    exc  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(WORD_SIZE-8){1'b0}}, byte_sel};
      F3_LH: begin
        if (offset[0]) exc = 1'b1;
        else           data = {{(WORD_SIZE-16){half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (offset[0]) exc = 1'b1;
        else           data = {{(WORD_SIZE-16){1'b0}}, half_sel};
      end
      F3_LW: begin
        if (offset != 2'b00) exc = 1'b1;
        else                 data = rdata;
      end
      default: exc = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment and instret
module mem_wb_stage #(
  parameter int WORD_SIZE     = mem_wb_stage_pkg::WORD_SIZE,
  parameter int PC_SIZE       = mem_wb_stage_pkg::PC_SIZE,
  parameter int REG_ADDR_SIZE = mem_wb_stage_pkg::REG_ADDR_SIZE
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [PC_SIZE-1:0]       i_pc,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
  input  logic                     i_reg_we,
  input  logic                     i_mem_to_reg,
  input  logic [2:0]               i_funct3,
  input  logic [WORD_SIZE-1:0]     i_alu_result,
  input  logic [WORD_SIZE-1:0]     i_mem_rdata,
  input  logic                     i_stall,
  input  logic                     i_flush,
  output logic                     o_wb_valid,
  output logic [PC_SIZE-1:0]       o_wb_pc,
  output logic [REG_ADDR_SIZE-1:0] o_rd_addr,
  output logic                     o_rd_we,
  output logic [WORD_SIZE-1:0]     o_rd_wdata,
  output logic                     o_load_exc,
  output logic [63:0]              o_instret
);

  logic [WORD_SIZE-1:0] load_data;
  logic                 load_exc;
  logic                 exc_next;
  logic                 we_next;
  logic [WORD_SIZE-1:0] wdata_next;
  logic [63:0]          instret_q;

  load_align #(.WORD_SIZE(WORD_SIZE)) u_load_align (
    .funct3 (i_funct3),
    .offset (i_alu_result[1:0]),
    .rdata  (i_mem_rdata),
    .data   (load_data),
    .exc    (load_exc)
  );

  // Alignment faults only matter for a real load instruction.
  assign exc_next   = i_valid & i_mem_to_reg & load_exc;
  assign we_next    = i_valid & i_reg_we & (i_rd_addr != '0) & ~exc_next;
  assign wdata_next = exc_next ? '0 : (i_mem_to_reg ? load_data : i_alu_result);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_valid <= 1'b0;
      o_wb_pc    <= '0;
      o_rd_addr  <= '0;
      o_rd_we    <= 1'b0;
      o_rd_wdata <= '0;
      o_load_exc <= 1'b0;
      instret_q  <= '0;
    end else if (i_flush) begin
      o_wb_valid <= 1'b0;
      o_rd_we    <= 1'b0;
      o_load_exc <= 1'b0;
    end else if (!i_stall) begin
      o_wb_valid <= i_valid;
      o_wb_pc    <= i_pc;
      o_rd_addr  <= i_rd_addr;
      o_rd_we    <= we_next;
      o_rd_wdata <= wdata_next;
      o_load_exc <= exc_next;
      if (i_valid && !exc_next) instret_q <= instret_q + 64'd1;
    end
  end

  assign o_instret = instret_q;

endmodule
